// File: rtl/uart_pkg.sv
// Shared constants, state encodings and helpers for the parametrised UART core.
// Both the TX and RX paths derive all bit timing from OVERSAMPLE ticks per bit.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAITHIGH
    } rxState_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample clock-enable generator: one-cycle tick every CLOCK_SCALE masterClock cycles.
// restart forces the count back to zero so the next tick lands a full period later.
module uart_baud_tick #(
    parameter int CLOCK_SCALE = 10
) (
    input  logic masterClock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLOCK_SCALE > 2) ? $clog2(CLOCK_SCALE) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLOCK_SCALE - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST_COUNT);

    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_core_param.sv
// Single-clock UART with valid/ready transmit, 16x oversampled majority-vote receive,
// and parity/framing/overrun status held alongside the last received word.
//
// TX state  | meaning
// TX_IDLE   | line high, ready for a new word
// TX_START  | driving start bit (0)
// TX_DATA   | shifting data bits out LSB first
// TX_PARITY | driving parity bit
// TX_STOP   | driving STOP_BITS stop bits (1)
//
// RX state    | meaning
// RX_IDLE     | waiting for synced rx low on a tick
// RX_START    | qualifying start bit at mid-bit
// RX_DATA     | sampling data bits
// RX_PARITY   | sampling parity bit
// RX_STOP     | sampling first stop bit, then publishing the word
// RX_WAITHIGH | holding off until the line returns high
module uart_core_param
    import uart_pkg::*;
#(
    parameter int CLOCK_SCALE = 10,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 masterClock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] txData,
    input  logic                 txValid,
    output logic                 txReady,
    output logic                 txActive,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    input  logic                 rxAck,
    output logic                 parityError,
    output logic                 framingError,
    output logic                 dataOverrun
);

    localparam logic [2:0] LAST_DATA   = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP   = 3'(STOP_BITS - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SAMPLE_A    = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] SAMPLE_B    = 4'(MID_SAMPLE);
    localparam logic [3:0] SAMPLE_VOTE = 4'(MID_SAMPLE + 1);

    // ------------------------------------------------------------------ TX
    txState_t             txState, txStateNext;
    logic [DATA_BITS-1:0] txShift;
    logic                 txParity;
    logic [3:0]           txSample;
    logic [2:0]           txBit;
    logic                 txTick, txBitDone, txLastStop, txAccept;

    uart_baud_tick #(.CLOCK_SCALE(CLOCK_SCALE)) txBaud (
        .masterClock (masterClock),
        .reset       (reset),
        .restart     (txAccept),
        .tick        (txTick)
    );

    assign txBitDone  = txTick && (txSample == SAMPLE_LAST);
    assign txLastStop = (txState == TX_STOP) && txBitDone && (txBit == LAST_STOP);
    // Ready during the final stop-bit cycle lets back-to-back words run with no idle gap.
    assign txReady    = (txState == TX_IDLE) || txLastStop;
    assign txActive   = !txReady;
    assign txAccept   = txValid && txReady;

    always_comb begin
        txStateNext = txState;
        tx          = 1'b1;
        case (txState)
            TX_IDLE: begin
                if (txAccept) txStateNext = TX_START;
            end
            TX_START: begin
                tx = 1'b0;
                if (txBitDone) txStateNext = TX_DATA;
            end
            TX_DATA: begin
                tx = txShift[0];
                if (txBitDone && (txBit == LAST_DATA))
                    txStateNext = (PARITY == PARITY_NONE) ? TX_STOP : TX_PARITY;
            end
            TX_PARITY: begin
                tx = txParity;
                if (txBitDone) txStateNext = TX_STOP;
            end
            TX_STOP: begin
                if (txLastStop) txStateNext = txAccept ? TX_START : TX_IDLE;
            end
            default: txStateNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            txState  <= TX_IDLE;
            txShift  <= '0;
            txParity <= 1'b0;
            txSample <= '0;
            txBit    <= '0;
        end else begin
            txState <= txStateNext;
            if (txAccept) begin
                txShift  <= txData;
                txParity <= (PARITY == PARITY_ODD) ? ~(^txData) : ^txData;
                txSample <= '0;
                txBit    <= '0;
            end else if (txTick) begin
                txSample <= txSample + 4'd1;
                if (txBitDone) begin
                    if (txState == TX_DATA) txShift <= txShift >> 1;
                    txBit <= (txStateNext == txState) ? txBit + 3'd1 : 3'd0;
                end
            end
        end
    end

    // ------------------------------------------------------------------ RX
    rxState_t             rxState, rxStateNext;
    logic                 rxMeta, rxSync;
    logic [3:0]           rxSample, rxIdx;
    logic                 rxS7, rxS8;
    logic [2:0]           rxBit;
    logic [DATA_BITS-1:0] rxShift;
    logic                 rxParityErr, rxParityExp;
    logic                 rxTick, rxVote, rxVoteNow, rxWordDone;

    // Holding the counter in WAITHIGH re-phases the oversampler to each new frame.
    uart_baud_tick #(.CLOCK_SCALE(CLOCK_SCALE)) rxBaud (
        .masterClock (masterClock),
        .reset       (reset),
        .restart     (rxState == RX_WAITHIGH),
        .tick        (rxTick)
    );

    assign rxIdx       = rxSample + 4'd1;
    assign rxVoteNow   = rxTick && (rxIdx == SAMPLE_VOTE);
    assign rxVote      = majority3(rxS7, rxS8, rxSync);
    assign rxWordDone  = (rxState == RX_STOP) && rxVoteNow;
    assign rxParityExp = (PARITY == PARITY_ODD) ? ~(^rxShift) : ^rxShift;

    always_comb begin
        rxStateNext = rxState;
        case (rxState)
            RX_IDLE: begin
                if (rxTick && !rxSync) rxStateNext = RX_START;
            end
            RX_START: begin
                if (rxVoteNow) rxStateNext = rxVote ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rxVoteNow && (rxBit == LAST_DATA))
                    rxStateNext = (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
            end
            RX_PARITY: begin
                if (rxVoteNow) rxStateNext = RX_STOP;
            end
            RX_STOP: begin
                if (rxVoteNow) rxStateNext = RX_WAITHIGH;
            end
            RX_WAITHIGH: begin
                if (rxSync) rxStateNext = RX_IDLE;
            end
            default: rxStateNext = RX_WAITHIGH;
        endcase
    end

    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            rxMeta       <= 1'b0;
            rxSync       <= 1'b0;
            rxState      <= RX_WAITHIGH;
            rxSample     <= '0;
            rxS7         <= 1'b0;
            rxS8         <= 1'b0;
            rxBit        <= '0;
            rxShift      <= '0;
            rxParityErr  <= 1'b0;
            rxData       <= '0;
            rxValid      <= 1'b0;
            parityError  <= 1'b0;
            framingError <= 1'b0;
            dataOverrun  <= 1'b0;
        end else begin
            rxMeta  <= rx;
            rxSync  <= rxMeta;
            rxState <= rxStateNext;

            if ((rxState == RX_IDLE) || (rxState == RX_WAITHIGH)) begin
                rxSample <= '0;
            end else if (rxTick) begin
                rxSample <= rxIdx;
                if (rxIdx == SAMPLE_A) rxS7 <= rxSync;
                if (rxIdx == SAMPLE_B) rxS8 <= rxSync;
            end

            if (rxState == RX_START) begin
                rxBit       <= '0;
                rxParityErr <= 1'b0;
            end
            if (rxVoteNow && (rxState == RX_DATA)) begin
                rxShift <= {rxVote, rxShift[DATA_BITS-1:1]};
                rxBit   <= rxBit + 3'd1;
            end
            if (rxVoteNow && (rxState == RX_PARITY)) begin
                rxParityErr <= (rxVote != rxParityExp);
            end

            // A word landing in the same cycle as rxAck takes precedence over the clear.
            if (rxWordDone) begin
                rxData       <= rxShift;
                rxValid      <= 1'b1;
                parityError  <= rxParityErr;
                framingError <= !rxVote;
                dataOverrun  <= rxValid && !rxAck;
            end else if (rxAck) begin
                rxValid      <= 1'b0;
                parityError  <= 1'b0;
                framingError <= 1'b0;
                dataOverrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: three instances (8N1 loopback, 7E1, 8N2) driven by directed frames.
// Received words are checked by a queue-based monitor; TX waveforms and timing checked inline.
module tb_uart_core_param;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       ov;
    } rxExp_t;

    logic masterClock = 1'b0;
    always #5 masterClock = ~masterClock;

    int cycleCnt = 0;
    always @(posedge masterClock) cycleCnt <= cycleCnt + 1;

    int testsRun = 0;
    int testsFailed = 0;

    rxExp_t qA[$];
    rxExp_t qB[$];

    logic resetAB, resetC;

    // Instance A: 8N1, rx either looped from tx or driven by the bench
    logic [7:0] txDataA, rxDataA;
    logic txValidA, txReadyA, txActiveA, txA, rxA, rxValidA, rxAckA, peA, feA, ovA;
    logic loopA, rxBenchA;
    assign rxA = loopA ? txA : rxBenchA;

    uart_core_param #(.CLOCK_SCALE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
        .masterClock(masterClock), .reset(resetAB),
        .txData(txDataA), .txValid(txValidA), .txReady(txReadyA), .txActive(txActiveA), .tx(txA),
        .rx(rxA), .rxData(rxDataA), .rxValid(rxValidA), .rxAck(rxAckA),
        .parityError(peA), .framingError(feA), .dataOverrun(ovA)
    );

    // Instance B: 7 data bits, even parity
    logic [6:0] txDataB, rxDataB;
    logic txValidB, txReadyB, txActiveB, txB, rxB, rxValidB, rxAckB, peB, feB, ovB;
    logic loopB, rxBenchB;
    assign rxB = loopB ? txB : rxBenchB;

    uart_core_param #(.CLOCK_SCALE(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dutB (
        .masterClock(masterClock), .reset(resetAB),
        .txData(txDataB), .txValid(txValidB), .txReady(txReadyB), .txActive(txActiveB), .tx(txB),
        .rx(rxB), .rxData(rxDataB), .rxValid(rxValidB), .rxAck(rxAckB),
        .parityError(peB), .framingError(feB), .dataOverrun(ovB)
    );

    // Instance C: 8N2, transmit timing and reset abort
    logic [7:0] txDataC, rxDataC;
    logic txValidC, txReadyC, txActiveC, txC, rxValidC, peC, feC, ovC;

    uart_core_param #(.CLOCK_SCALE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dutC (
        .masterClock(masterClock), .reset(resetC),
        .txData(txDataC), .txValid(txValidC), .txReady(txReadyC), .txActive(txActiveC), .tx(txC),
        .rx(1'b1), .rxData(rxDataC), .rxValid(rxValidC), .rxAck(1'b0),
        .parityError(peC), .framingError(feC), .dataOverrun(ovC)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge masterClock);
        #1;
    endtask

    function automatic logic getTx(input int which);
        if (which == 0) return txA;
        if (which == 1) return txB;
        return txC;
    endfunction

    function automatic logic getValid(input int which);
        return (which == 0) ? rxValidA : rxValidB;
    endfunction

    function automatic rxExp_t getWord(input int which);
        if (which == 0) return {rxDataA, peA, feA, ovA};
        return {1'b0, rxDataB, peB, feB, ovB};
    endfunction

    task automatic setRx(input int which, input logic v);
        if (which == 0) rxBenchA = v;
        else rxBenchB = v;
    endtask

    task automatic driveFrame(input int which, input logic [15:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            setRx(which, bits[k]);
            cyc(64);
        end
        setRx(which, 1'b1);
    endtask

    // Called at #1 after the accept edge; checks first and last cycle of every bit.
    task automatic checkTxFrame(input int which, input logic [15:0] bits, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s bit%0d head", name, k), getTx(which), bits[k]);
            cyc(63);
            check($sformatf("%s bit%0d tail", name, k), getTx(which), bits[k]);
            cyc(1);
        end
    endtask

    task automatic startTx(input int which, input logic [7:0] d);
        if (which == 0) begin
            check("A ready before send", txReadyA, 1'b1);
            txDataA = d; txValidA = 1'b1;
            cyc(1);
            txValidA = 1'b0;
            check("A accept flags", {txReadyA, txActiveA}, 2'b01);
        end else begin
            check("B ready before send", txReadyB, 1'b1);
            txDataB = d[6:0]; txValidB = 1'b1;
            cyc(1);
            txValidB = 1'b0;
            check("B accept flags", {txReadyB, txActiveB}, 2'b01);
        end
    endtask

    task automatic ack(input int which);
        for (int i = 0; i < 3000 && !getValid(which); i++) cyc(1);
        check($sformatf("ch%0d rxValid before ack", which), getValid(which), 1'b1);
        if (which == 0) rxAckA = 1'b1; else rxAckB = 1'b1;
        cyc(1);
        if (which == 0) rxAckA = 1'b0; else rxAckB = 1'b0;
        if (which == 0)
            check("A cleared after ack", {rxValidA, peA, feA, ovA}, 4'b0000);
        else
            check("B cleared after ack", {rxValidB, peB, feB, ovB}, 4'b0000);
    endtask

    // Monitor: a new word is a rise of rxValid or a change of data/flags while valid.
    initial begin
        logic   prevValid[2];
        rxExp_t prevWord[2];
        rxExp_t cur;
        rxExp_t exp;
        prevValid[0] = 1'b0; prevValid[1] = 1'b0;
        prevWord[0] = '0; prevWord[1] = '0;
        forever begin
            @(negedge masterClock);
            for (int w = 0; w < 2; w++) begin
                cur = getWord(w);
                if (getValid(w) && (!prevValid[w] || cur != prevWord[w])) begin
                    if ((w == 0 && qA.size() == 0) || (w == 1 && qB.size() == 0)) begin
                        check($sformatf("ch%0d unexpected word", w), {getValid(w), cur}, 12'h000);
                    end else begin
                        exp = (w == 0) ? qA.pop_front() : qB.pop_front();
                        check($sformatf("ch%0d rx word {data,pe,fe,ov}", w), cur, exp);
                    end
                end
                prevValid[w] = getValid(w);
                prevWord[w]  = cur;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        logic found;

        resetAB = 1'b0; resetC = 1'b0;
        txDataA = '0; txValidA = 1'b0; rxAckA = 1'b0; loopA = 1'b1; rxBenchA = 1'b1;
        txDataB = '0; txValidB = 1'b0; rxAckB = 1'b0; loopB = 1'b1; rxBenchB = 1'b1;
        txDataC = '0; txValidC = 1'b0;
        cyc(3);
        check("A reset tx/ready/active", {txA, txReadyA, txActiveA}, 3'b110);
        check("A reset rx outputs", {rxDataA, rxValidA, peA, feA, ovA}, 12'h000);
        check("B reset rx outputs", {rxDataB, rxValidB, peB, feB, ovB}, 11'h000);
        check("C reset tx/ready/active", {txC, txReadyC, txActiveC}, 3'b110);
        resetAB = 1'b1; resetC = 1'b1;
        cyc(10);

        // 8N1 loopback of A5: start, 1,0,1,0,0,1,0,1, stop
        qA.push_back({8'hA5, 1'b0, 1'b0, 1'b0});
        startTx(0, 8'hA5);
        checkTxFrame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, "A tx A5");
        check("A idle after frame", {txA, txReadyA, txActiveA}, 3'b110);
        ack(0);

        // 7E1 loopback of 55: parity bit 0
        qB.push_back({8'h55, 1'b0, 1'b0, 1'b0});
        startTx(1, 8'h55);
        checkTxFrame(1, {6'b0, 1'b1, 1'b0, 7'h55, 1'b0}, 10, "B tx 55");
        ack(1);

        // 7E1 with wrong parity forced on the line
        loopB = 1'b0;
        cyc(4);
        qB.push_back({8'h55, 1'b1, 1'b0, 1'b0});
        driveFrame(1, {6'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 10);
        ack(1);

        // Glitch of 3 ticks is rejected, next frame received
        loopA = 1'b0;
        cyc(4);
        rxBenchA = 1'b0;
        cyc(12);
        rxBenchA = 1'b1;
        cyc(128);
        check("A glitch no rxValid", rxValidA, 1'b0);
        qA.push_back({8'h3C, 1'b0, 1'b0, 1'b0});
        driveFrame(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        ack(0);

        // Overrun: 11 then 22 without ack
        qA.push_back({8'h11, 1'b0, 1'b0, 1'b0});
        qA.push_back({8'h22, 1'b0, 1'b0, 1'b1});
        driveFrame(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        driveFrame(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
        cyc(16);
        check("A overrun state", {rxDataA, rxValidA, ovA}, {8'h22, 1'b1, 1'b1});
        ack(0);

        // Break: 12 bit times low -> exactly one 00 word with framing error
        qA.push_back({8'h00, 1'b0, 1'b1, 1'b0});
        rxBenchA = 1'b0;
        cyc(12 * 64);
        rxBenchA = 1'b1;
        cyc(128);
        check("A break single word", {rxValidA, feA, ovA}, 3'b110);
        ack(0);
        qA.push_back({8'h5A, 1'b0, 1'b0, 1'b0});
        driveFrame(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        ack(0);

        // 8N2 back-to-back words with txValid held high
        check("C ready before send", txReadyC, 1'b1);
        txDataC = 8'h81; txValidC = 1'b1;
        cyc(1);
        t1 = cycleCnt;
        check("C start1 low", {txC, txActiveC}, 2'b01);
        txDataC = 8'h7E;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cyc(1);
            if (txReadyC) begin
                found = 1'b1;
                break;
            end
        end
        check("C ready seen", found, 1'b1);
        cyc(1);
        t2 = cycleCnt;
        txValidC = 1'b0;
        check("C start2 low", {txC, txActiveC}, 2'b01);
        check("C start-to-start gap", t2 - t1, 704);

        // Reset mid-frame (inside data bit 0 of 7E, which is low)
        cyc(80);
        check("C mid-frame low", txC, 1'b0);
        resetC = 1'b0;
        #1;
        check("C async reset abort", {txC, txReadyC, txActiveC}, 3'b110);
        cyc(3);
        resetC = 1'b1;
        cyc(5);
        check("C idle after reset", {txC, txReadyC, txActiveC}, 3'b110);

        cyc(10);
        check("A queue drained", qA.size(), 0);
        check("B queue drained", qB.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
